// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the input debouncer.
// Board-clock (100 MHz) debounce windows expressed in clk cycles.
package debounce_pkg;

   localparam int unsigned DEB_1MS  = 100_000;
   localparam int unsigned DEB_10MS = 1_000_000;
   localparam int unsigned DEB_20MS = 2_000_000;

   // Ceiling log2; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned v;
      int unsigned r;
      r = 0;
      v = (n > 0) ? n - 1 : 0;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchronizer chain, stability counter, level and edge-pulse registers.
module debounce_ch
   import debounce_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam int unsigned     CntW   = clog2(STABLE_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   dout_q, dout_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   // din is sampled only by the first synchronizer stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      cnt_d  = '0;
      dout_d = dout_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (s != dout_q) begin
         if (cnt_q == CntMax) begin
            dout_d = s;
            rise_d = s;
            fall_d = ~s;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         dout_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign dout = dout_q;
   assign rise = rise_q;
   assign fall = fall_q;
   assign busy = s ^ dout_q;

endmodule

// File: rtl/debounce_sync.sv
// Multi-channel input conditioner: independent debounce_ch per input bit.
module debounce_sync
   import debounce_pkg::*;
#(
   parameter int unsigned WIDTH         = 1,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] busy
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      debounce_ch #(
         .SYNC_STAGES  (SYNC_STAGES),
         .STABLE_CYCLES(STABLE_CYCLES)
      ) u_ch (
         .clk (clk),
         .rst (rst),
         .din (din[i]),
         .dout(dout[i]),
         .rise(rise[i]),
         .fall(fall[i]),
         .busy(busy[i])
      );
   end

endmodule

// File: doc/debounce_sync.md
# debounce_sync

Multi-channel input conditioner that takes raw asynchronous level signals (push-buttons, switches, external strobes), synchronizes them into the `clk` domain, filters out bounce and glitches, and emits clean debounced levels plus single-cycle rising and falling edge pulses. It sits directly upstream of the team's registered storage stages (D flip-flops, toggles, counters) and feeds them glitch-free, clock-aligned data and enable pulses.

## Interface
- `WIDTH`, 1: number of independent channels.
- `SYNC_STAGES`, 2: synchronizer depth; legal values are 2 or more.
- `STABLE_CYCLES`, 16: consecutive cycles a new level must persist before it is accepted; legal values are 1 or more.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high; clock `clk`.
- `din`  in  `WIDTH`  raw asynchronous inputs.
- `dout`  out  `WIDTH`  debounced level, registered.
- `rise`  out  `WIDTH`  one-cycle pulse when `dout[i]` goes 0→1, registered.
- `fall`  out  `WIDTH`  one-cycle pulse when `dout[i]` goes 1→0, registered.
- `busy`  out  `WIDTH`  high while channel i has a pending, unaccepted level change. Defined as `s[i] != dout[i]`; combinational from flops.

## Operation
- Channels are fully independent. There is no cross-channel interaction.
- Synchronizer:
  - `SYNC_STAGES` flops per channel; the first flop samples `din[i]`.
  - `s[i]` is the last stage.
- Counter:
  - Per channel, width `$clog2(STABLE_CYCLES+1)`.
  - Its value never exceeds `STABLE_CYCLES-1`, so no wrap is possible.
- Per-channel behaviour on each clk edge (not in reset):
  - If `s == dout`: clear `cnt`; `dout` unchanged; `rise` and `fall` low.
  - If `s != dout` and `cnt < STABLE_CYCLES-1`: increment `cnt`; `rise` and `fall` low.
  - If `s != dout` and `cnt == STABLE_CYCLES-1`: load `dout <= s` and clear `cnt`. Set `rise <= s` and `fall <= ~s`.
- Glitch rejection:
  - Any return of `s` to the current `dout` value before acceptance clears `cnt`. No output change and no pulse result.
  - Counting restarts from zero on the next mismatch.
- `rise` and `fall` are never high together, and each lasts exactly one cycle per accepted transition.
- `STABLE_CYCLES = 1`: a change is accepted on the first cycle `s` differs from `dout`.

## Timing
- Reset: while `rst` is high at a clk edge, all synchronizer flops, `cnt`, `dout`, `rise` and `fall` are cleared to 0. `busy` is therefore 0.
- Latency:
  - A clean step on `din[i]` is first captured at edge E.
  - `dout[i]`, and the matching `rise[i]`/`fall[i]`, update at edge E + `SYNC_STAGES` + `STABLE_CYCLES` − 1.
  - With the defaults this is E+17.
- The edge pulse is coincident with the `dout` change. Downstream logic may use `rise`/`fall` as clock enables directly.
- `busy[i]` is asserted from edge E + `SYNC_STAGES` − 1 until the acceptance edge.
- If `din` is high while `rst` is asserted, the first sample is taken at the first edge after `rst` deasserts (edge E). It is then accepted with full latency and produces a `rise` pulse.
- If `rst` is asserted mid-count, the count is discarded with no pulse. `dout` returns to 0 on that edge, and no `fall` pulse is generated by reset.
- Input toggling faster than `STABLE_CYCLES` indefinitely: `dout` holds its last accepted value forever.
- Metastability is handled only by the synchronizer chain. No other logic samples `din` directly.

## Structure
- Shared package `debounce_pkg` holds:
  - Standard `STABLE_CYCLES` constants for the 100 MHz board clock: `DEB_1MS` = 100_000, `DEB_10MS` = 1_000_000, `DEB_20MS` = 2_000_000.
  - A `clog2` helper function.
- Sub-module `debounce_ch` covers one channel: synchronizer, counter, level register and pulse registers.
- The top level instantiates `debounce_ch` `WIDTH` times in a generate loop.

## Test plan
- Reset: hold `rst` for 3 cycles with `din`=`'1` → `dout`, `rise`, `fall` and `busy` all 0 during reset. After release, `rise` pulses once, at the 18th edge after release (defaults).
- Clean step, defaults: `din[0]` 0→1 captured at edge E → `dout[0]`=1 and `rise[0]`=1 at E+17 only, then `rise[0]`=0. The reverse step gives `fall[0]` at the corresponding edge.
- Glitch rejection: with `STABLE_CYCLES`=16, a `din` high pulse lasting 10 cycles → `busy` asserts, `dout` stays 0, and no `rise`. A second pulse lasting 16 cycles is accepted.
- Bounce: `din` toggles every 3 cycles for 50 cycles, then settles high → exactly one `rise`, 17 edges after the settling sample.
- Reset mid-count: `dout`=1 and `din` falls; assert `rst` when `cnt`=8 → `dout`=0 on the next edge, no `fall` pulse, `cnt`=0.
- Multi-channel independence: `WIDTH`=4, `STABLE_CYCLES`=1 → steps on channels 0 and 3 in the same cycle pulse together after 2 edges; channels 1 and 2 stay quiet.
